ledpanel_fb_writer: RTL and testbench
=====================================

Name: ledpanel_fb_writer

Overview:
- Producer end of the LED panel frame-buffer interface: the write side of the double-buffered bitplane BRAM that the panel scan driver reads.
- Accepts a raster-order 24-bit RGB pixel stream, slices each pixel into bitplanes and writes them into the buffer not being displayed.
- Packs top-half and bottom-half rows into the shared 6-bit word {r0,g0,b0,r1,g1,b1} using a per-lane write mask.
- Tracks frames, reports frame completion and flags tearing, i.e. when the display side swaps onto the buffer still being written.

Parameters:
- N_ROWS_MAX, 64, maximum panel rows.
- N_COLS_MAX, 256, maximum chained columns.
- BITDEPTH_MAX, 8, bits per colour in the input and maximum plane count.
- MEM_DEPTH, N_ROWS_MAX*N_COLS_MAX, derived; do not override.
- R_MEM_ADDR_WIDTH, $clog2(MEM_DEPTH)-1, derived; half-frame word address width.
- R_MEM_DATA_WIDTH, 6, derived; BRAM word width.

Ports:
- clk  in  1  single clock for all logic.
- ctrl_rst_n  in  1  asynchronous, active-low reset.
- ctrl_en  in  1  enable; low aborts the frame in progress.
- ctrl_n_rows  in  32  active rows; even, ≤ N_ROWS_MAX.
- ctrl_n_cols  in  32  active columns.
- ctrl_bitdepth  in  32  planes to write, 1..BITDEPTH_MAX.
- pix_valid  in  1  pixel valid.
- pix_ready  out  1  pixel accepted when valid&&ready at the rising edge.
- pix_sof  in  1  qualifies the first pixel of a frame.
- pix_data  in  3*BITDEPTH_MAX  {R,G,B}, MSB-first.
- disp_buffer  in  1  buffer currently displayed by the scan driver.
- mem_wr_en  out  1  write strobe.
- mem_wr_buffer  out  1  target buffer.
- mem_wr_addr  out  R_MEM_ADDR_WIDTH  half-frame word address.
- mem_wr_bit  out  $clog2(BITDEPTH_MAX)  plane index.
- mem_wr_data  out  6  {r0,g0,b0,r1,g1,b1}.
- mem_wr_mask  out  6  per-lane write enable.
- stat_frame_done  out  1  one-cycle pulse when a frame completes.
- stat_overrun  out  1  one-cycle pulse on tearing.
- stat_sof_err  out  1  one-cycle pulse on an unexpected SOF.

Behaviour:

Reset (async assert, sync release):
- All outputs are 0; the FSM enters SYNC.

FSM:
- SYNC:
  - pix_ready=1; pixels without SOF are consumed and dropped, with no write.
  - A SOF beat latches the pixel, sets row=0, col=0, sets mem_wr_buffer=~disp_buffer, clears the overrun flag, and goes to WRITE.
- ACCEPT:
  - pix_ready=1.
  - A beat without SOF latches the pixel and goes to WRITE.
  - A beat with SOF pulses stat_sof_err, restarts at row 0, col 0, re-latches the buffer as in SYNC, then goes to WRITE.
- WRITE:
  - pix_ready=0; plane counter k runs 0..ctrl_bitdepth-1, one write per cycle with mem_wr_en=1 and mem_wr_bit=k.
  - Plane k takes bit index (BITDEPTH_MAX-ctrl_bitdepth+k) of each colour, so plane 0 is the displayed LSB.
  - After the last plane, advance col, then row.
  - If that was the last pixel (row=ctrl_n_rows-1, col=ctrl_n_cols-1), pulse stat_frame_done on the cycle after the final write and go to SYNC; otherwise go to ACCEPT.

Timing:
- Throughput is one pixel per ctrl_bitdepth+1 cycles.
- Latency is 1 cycle from accept to the plane-0 write.

Addressing:
- h = ctrl_n_rows/2.
- Top half (row<h): mem_wr_addr=row*ctrl_n_cols+col, data in bits[5:3], mask 6'b111000, other lanes 0.
- Bottom half (row≥h): mem_wr_addr=(row-h)*ctrl_n_cols+col, data in bits[2:0], mask 6'b000111.
- Products are computed at full width and truncated to R_MEM_ADDR_WIDTH.

Overrun:
- Outside SYNC, if disp_buffer==mem_wr_buffer, pulse stat_overrun once per frame.
- Writing continues; the frame is not restarted.

ctrl_en low:
- Takes effect the next cycle: mem_wr_en=0, pix_ready=0, state→SYNC, any partial pixel is discarded, and no status pulse is issued.

Config changes:
- ctrl_* changes mid-frame are undefined.
- ctrl_bitdepth=0 is treated as 1.

Test Plan:
1. Cfg 4x2, bitdepth 8, disp_buffer=0; SOF pixel 0xFF0080 at (0,0):
   - 8 writes: buffer 1, addr 0, mask 111000.
   - Planes 0-6 data 100000; plane 7 data 101000.
2. Same frame, pixel (2,1)=0x00FF00:
   - addr 1, mask 000111, all planes data 000010.
   - After pixel 8, frame_done pulses once and the FSM returns to SYNC.
3. bitdepth 4, pixel 0x1F0000: planes 0-3 R bits 4..7 give data 100000,000000,000000,000000; pix_ready period is 5 cycles.
4. Non-SOF pixels before any SOF: accepted with no writes. SOF asserted at the third pixel of a frame: sof_err pulses and the next write goes to addr 0.
5. disp_buffer toggles to equal mem_wr_buffer mid-frame, twice: exactly one stat_overrun pulse and writes continue.
6. ctrl_rst_n low, or ctrl_en dropped, during WRITE plane 3:
   - ctrl_rst_n low: all outputs are 0 immediately.
   - ctrl_en dropped: outputs are 0 on the next cycle.
   - In both cases no further writes occur until a new SOF.

Source files
------------

// File: rtl/ledpanel_fb_writer_if.sv
// Pixel-stream and bitplane-write buses of the LED panel frame-buffer writer.
// Parameters must match the writer instance they connect to.
interface ledpanel_pix_if #(
    parameter int BITDEPTH_MAX = 8
);
    logic                      valid;
    logic                      ready;
    logic                      sof;
    logic [3*BITDEPTH_MAX-1:0] data;

    modport master (output valid, output sof, output data, input ready);
    modport slave  (input valid, input sof, input data, output ready);
endinterface

interface ledpanel_mem_if #(
    parameter int ADDR_WIDTH = 13,
    parameter int BIT_WIDTH  = 3,
    parameter int DATA_WIDTH = 6
);
    logic                  wr_en;
    logic                  wr_buffer;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BIT_WIDTH-1:0]  wr_bit;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] wr_mask;

    modport master (output wr_en, output wr_buffer, output wr_addr, output wr_bit,
                    output wr_data, output wr_mask);
    modport slave  (input wr_en, input wr_buffer, input wr_addr, input wr_bit,
                    input wr_data, input wr_mask);
endinterface

// File: rtl/ledpanel_fb_writer.sv
// Slices RGB pixels into bitplanes and writes them into the non-displayed buffer half.
// Plane 0 written 1 cycle after accept; pix.ready stays low for the bitdepth write cycles.
module ledpanel_fb_writer #(
    parameter int  N_ROWS_MAX       = 64,
    parameter int  N_COLS_MAX       = 256,
    parameter int  BITDEPTH_MAX     = 8,
    localparam int MEM_DEPTH        = N_ROWS_MAX * N_COLS_MAX,
    localparam int R_MEM_ADDR_WIDTH = $clog2(MEM_DEPTH) - 1,
    localparam int R_MEM_DATA_WIDTH = 6
) (
    input  logic          clk,
    input  logic          ctrl_rst_n,
    input  logic          ctrl_en,
    input  logic [31:0]   ctrl_n_rows,
    input  logic [31:0]   ctrl_n_cols,
    input  logic [31:0]   ctrl_bitdepth,
    ledpanel_pix_if.slave pix,
    input  logic          disp_buffer,
    ledpanel_mem_if.master mem,
    output logic          stat_frame_done,
    output logic          stat_overrun,
    output logic          stat_sof_err
);
    localparam int BIT_WIDTH = $clog2(BITDEPTH_MAX);

    typedef enum logic [1:0] {SYNC, ACCEPT, WRITE} state_t;

    state_t                    state;
    logic [3*BITDEPTH_MAX-1:0] pix_q;
    logic                      top_q;
    logic                      ovr_seen;
    logic [31:0]               row;
    logic [31:0]               col;
    logic [31:0]               plane;

    logic [31:0] bd_eff;
    logic [31:0] last_plane;
    logic [31:0] nxt_plane;
    logic [31:0] half;
    logic [31:0] nxt_row;
    logic [31:0] nxt_col;
    logic [31:0] row_off;
    logic [31:0] addr_full;
    logic        nxt_top;
    logic        accept;
    logic        restart;
    logic        start;
    logic        last_pixel;

    // Picks bit (BITDEPTH_MAX - bd + plane) of each colour so plane 0 is the shown LSB.
    function automatic logic [R_MEM_DATA_WIDTH-1:0] lane_word(
        input logic [3*BITDEPTH_MAX-1:0] px,
        input logic [31:0]               plane_idx,
        input logic [31:0]               bd,
        input logic                      top
    );
        logic [BITDEPTH_MAX-1:0] r;
        logic [BITDEPTH_MAX-1:0] g;
        logic [BITDEPTH_MAX-1:0] b;
        logic [31:0]             bi;
        logic [BIT_WIDTH-1:0]    idx;
        logic [2:0]              rgb;
        r   = px[3*BITDEPTH_MAX-1 -: BITDEPTH_MAX];
        g   = px[2*BITDEPTH_MAX-1 -: BITDEPTH_MAX];
        b   = px[BITDEPTH_MAX-1 -: BITDEPTH_MAX];
        bi  = 32'(BITDEPTH_MAX) - bd + plane_idx;
        idx = BIT_WIDTH'(bi);
        rgb = {r[idx], g[idx], b[idx]};
        return top ? {rgb, 3'b000} : {3'b000, rgb};
    endfunction

    always_comb begin
        bd_eff = ctrl_bitdepth;
        if (ctrl_bitdepth == 32'd0) begin
            bd_eff = 32'd1;
        end else if (ctrl_bitdepth > 32'(BITDEPTH_MAX)) begin
            bd_eff = 32'(BITDEPTH_MAX);
        end
        last_plane = bd_eff - 32'd1;
        nxt_plane  = plane + 32'd1;
        half       = ctrl_n_rows >> 1;
        accept     = pix.valid && pix.ready;
        restart    = accept && pix.sof;
        start      = accept && (pix.sof || (state == ACCEPT));
        nxt_row    = pix.sof ? 32'd0 : row;
        nxt_col    = pix.sof ? 32'd0 : col;
        nxt_top    = nxt_row < half;
        row_off    = nxt_top ? nxt_row : (nxt_row - half);
        addr_full  = row_off * ctrl_n_cols + nxt_col;
        last_pixel = (row == ctrl_n_rows - 32'd1) && (col == ctrl_n_cols - 32'd1);
    end

    always_ff @(posedge clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            state           <= SYNC;
            pix_q           <= '0;
            top_q           <= 1'b0;
            ovr_seen        <= 1'b0;
            row             <= '0;
            col             <= '0;
            plane           <= '0;
            pix.ready       <= 1'b0;
            mem.wr_en       <= 1'b0;
            mem.wr_buffer   <= 1'b0;
            mem.wr_addr     <= '0;
            mem.wr_bit      <= '0;
            mem.wr_data     <= '0;
            mem.wr_mask     <= '0;
            stat_frame_done <= 1'b0;
            stat_overrun    <= 1'b0;
            stat_sof_err    <= 1'b0;
        end else if (!ctrl_en) begin
            // Abort: drop any partial pixel silently and wait for a fresh SOF.
            state           <= SYNC;
            ovr_seen        <= 1'b0;
            pix.ready       <= 1'b0;
            mem.wr_en       <= 1'b0;
            mem.wr_buffer   <= 1'b0;
            mem.wr_addr     <= '0;
            mem.wr_bit      <= '0;
            mem.wr_data     <= '0;
            mem.wr_mask     <= '0;
            stat_frame_done <= 1'b0;
            stat_overrun    <= 1'b0;
            stat_sof_err    <= 1'b0;
        end else begin
            stat_frame_done <= 1'b0;
            stat_overrun    <= 1'b0;
            stat_sof_err    <= 1'b0;

            // Tearing: display swapped onto the half we are filling; report once per frame.
            if ((state != SYNC) && !ovr_seen && !restart && (disp_buffer == mem.wr_buffer)) begin
                stat_overrun <= 1'b1;
                ovr_seen     <= 1'b1;
            end

            case (state)
                SYNC, ACCEPT: begin
                    pix.ready <= 1'b1;
                    if (start) begin
                        pix_q       <= pix.data;
                        row         <= nxt_row;
                        col         <= nxt_col;
                        top_q       <= nxt_top;
                        plane       <= '0;
                        pix.ready   <= 1'b0;
                        mem.wr_en   <= 1'b1;
                        mem.wr_addr <= R_MEM_ADDR_WIDTH'(addr_full);
                        mem.wr_bit  <= '0;
                        mem.wr_data <= lane_word(pix.data, 32'd0, bd_eff, nxt_top);
                        mem.wr_mask <= nxt_top ? 6'b111000 : 6'b000111;
                        state       <= WRITE;
                        if (pix.sof) begin
                            mem.wr_buffer <= ~disp_buffer;
                            ovr_seen      <= 1'b0;
                            if (state == ACCEPT) begin
                                stat_sof_err <= 1'b1;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (plane >= last_plane) begin
                        mem.wr_en   <= 1'b0;
                        mem.wr_addr <= '0;
                        mem.wr_bit  <= '0;
                        mem.wr_data <= '0;
                        mem.wr_mask <= '0;
                        pix.ready   <= 1'b1;
                        if (last_pixel) begin
                            stat_frame_done <= 1'b1;
                            state           <= SYNC;
                        end else begin
                            state <= ACCEPT;
                            if (col == ctrl_n_cols - 32'd1) begin
                                col <= '0;
                                row <= row + 32'd1;
                            end else begin
                                col <= col + 32'd1;
                            end
                        end
                    end else begin
                        plane       <= nxt_plane;
                        mem.wr_bit  <= BIT_WIDTH'(nxt_plane);
                        mem.wr_data <= lane_word(pix_q, nxt_plane, bd_eff, top_q);
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_ledpanel_fb_writer.sv
// Bench for ledpanel_fb_writer: vector table, hand-written corner sequences and random frames.
module tb_ledpanel_fb_writer;
    localparam int BD = 8;
    localparam int AW = 13;

    logic        clk = 1'b0;
    logic        ctrl_rst_n;
    logic        ctrl_en;
    logic [31:0] ctrl_n_rows;
    logic [31:0] ctrl_n_cols;
    logic [31:0] ctrl_bitdepth;
    logic        disp_buffer;
    logic        stat_frame_done;
    logic        stat_overrun;
    logic        stat_sof_err;

    always #5 clk = ~clk;

    ledpanel_pix_if #(.BITDEPTH_MAX(BD)) pix ();
    ledpanel_mem_if #(.ADDR_WIDTH(AW), .BIT_WIDTH(3), .DATA_WIDTH(6)) mem ();

    ledpanel_fb_writer #(.N_ROWS_MAX(64), .N_COLS_MAX(256), .BITDEPTH_MAX(BD)) dut (
        .clk             (clk),
        .ctrl_rst_n      (ctrl_rst_n),
        .ctrl_en         (ctrl_en),
        .ctrl_n_rows     (ctrl_n_rows),
        .ctrl_n_cols     (ctrl_n_cols),
        .ctrl_bitdepth   (ctrl_bitdepth),
        .pix             (pix),
        .disp_buffer     (disp_buffer),
        .mem             (mem),
        .stat_frame_done (stat_frame_done),
        .stat_overrun    (stat_overrun),
        .stat_sof_err    (stat_sof_err)
    );

    typedef struct packed {
        logic          buffer;
        logic [AW-1:0] addr;
        logic [2:0]    bitn;
        logic [5:0]    data;
        logic [5:0]    mask;
    } wr_t;

    typedef struct {
        int               rows;
        int               cols;
        int               bd;
        logic             disp;
        logic [23:0]      pixel;
        int               pos;
        logic             exp_buf;
        int               exp_addr;
        logic [5:0]       exp_mask;
        logic [7:0][5:0]  exp_data;
    } vec_t;

    wr_t         wlog[$];
    wr_t         expq[$];
    int          acc_cyc[$];
    int          w0_cyc[$];
    int          cyc = 0;
    int          n_done = 0;
    int          n_ovr = 0;
    int          n_sof = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [23:0] fpix [64];
    vec_t        vt [6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem.wr_en) begin
            wlog.push_back({mem.wr_buffer, mem.wr_addr, mem.wr_bit, mem.wr_data, mem.wr_mask});
            if (mem.wr_bit == 3'd0) w0_cyc.push_back(cyc);
        end
        if (pix.valid && pix.ready) acc_cyc.push_back(cyc);
        if (stat_frame_done) n_done++;
        if (stat_overrun) n_ovr++;
        if (stat_sof_err) n_sof++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired or entry missing", name);
    endtask

    function automatic logic [63:0] outs();
        return 64'({pix.ready, mem.wr_en, mem.wr_buffer, mem.wr_addr, mem.wr_bit, mem.wr_data,
                    mem.wr_mask, stat_frame_done, stat_overrun, stat_sof_err});
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] d, input logic sof);
        bit ok;
        ok = 1'b0;
        pix.valid = 1'b1;
        pix.sof   = sof;
        pix.data  = d;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (pix.ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        pix.valid = 1'b0;
        pix.sof   = 1'b0;
        if (!ok) fail_now("ready_timeout");
    endtask

    // Reference: expected plane writes of one pixel, straight from the addressing/slicing rules.
    task automatic model_pixel(input logic [23:0] d, input int row, input int col, input logic buffer);
        int  be, h, bi, rgb, cols;
        wr_t e;
        be   = (ctrl_bitdepth == 0) ? 1 : int'(ctrl_bitdepth);
        h    = int'(ctrl_n_rows) / 2;
        cols = int'(ctrl_n_cols);
        for (int k = 0; k < be; k++) begin
            bi  = BD - be + k;
            rgb = 4 * int'((d >> (16 + bi)) & 24'd1) + 2 * int'((d >> (8 + bi)) & 24'd1)
                  + int'((d >> bi) & 24'd1);
            e.buffer = buffer;
            e.bitn   = 3'(k);
            if (row < h) begin
                e.addr = AW'(row * cols + col);
                e.data = 6'(rgb * 8);
                e.mask = 6'b111000;
            end else begin
                e.addr = AW'((row - h) * cols + col);
                e.data = 6'(rgb);
                e.mask = 6'b000111;
            end
            expq.push_back(e);
        end
    endtask

    task automatic compare_writes(input string name);
        check({name, "_nwr"}, 64'(wlog.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < wlog.size(); i++)
            check({name, "_wr"}, 64'(wlog[i]), 64'(expq[i]));
    endtask

    task automatic run_frame(input int rows, input int cols, input int bd, input logic disp,
                             input string name);
        int d0;
        ctrl_n_rows   = rows;
        ctrl_n_cols   = cols;
        ctrl_bitdepth = bd;
        disp_buffer   = disp;
        idle(1);
        d0 = n_done;
        wlog.delete();
        expq.delete();
        for (int i = 0; i < rows * cols; i++) begin
            model_pixel(fpix[i], i / cols, i % cols, ~disp);
            send(fpix[i], i == 0);
            idle($urandom_range(0, 2));
        end
        idle(12);
        compare_writes(name);
        check({name, "_done"}, 64'(n_done - d0), 64'd1);
    endtask

    task automatic wait_plane3(input string name);
        bit hit;
        hit = 1'b0;
        for (int t = 0; t < 20 && !hit; t++) begin
            @(negedge clk);
            if (mem.wr_en && mem.wr_bit == 3'd3) hit = 1'b1;
        end
        if (!hit) fail_now(name);
    endtask

    initial begin
        int   d0, s0, o0, be, idx;
        wr_t  e;

        vt[0] = '{4, 2, 8, 1'b0, 24'hFF0080, 0, 1'b1, 0, 6'o70, {6'h28, {7{6'h20}}}};
        vt[1] = '{4, 2, 8, 1'b0, 24'h00FF00, 5, 1'b1, 1, 6'o07, {8{6'h02}}};
        vt[2] = '{4, 2, 4, 1'b0, 24'h1F0000, 0, 1'b1, 0, 6'o70, {{4{6'h00}}, 6'h00, 6'h00, 6'h00, 6'h20}};
        vt[3] = '{4, 2, 0, 1'b1, 24'h800000, 3, 1'b0, 3, 6'o70, {{7{6'h00}}, 6'h20}};
        vt[4] = '{4, 3, 2, 1'b0, 24'h40C0C0, 7, 1'b1, 1, 6'o07, {{6{6'h00}}, 6'h03, 6'h07}};
        vt[5] = '{6, 5, 1, 1'b0, 24'h800080, 29, 1'b1, 14, 6'o07, {{7{6'h00}}, 6'h05}};

        ctrl_rst_n    = 1'b0;
        ctrl_en       = 1'b1;
        ctrl_n_rows   = 4;
        ctrl_n_cols   = 2;
        ctrl_bitdepth = 8;
        disp_buffer   = 1'b0;
        pix.valid     = 1'b0;
        pix.sof       = 1'b0;
        pix.data      = '0;
        #12;
        check("reset_outs", outs(), 64'd0);
        @(negedge clk);
        ctrl_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("sync_ready", 64'(pix.ready), 64'd1);

        // Table vectors: one pixel of interest embedded in a full random frame.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 64; i++) fpix[i] = 24'($urandom);
            fpix[vt[v].pos] = vt[v].pixel;
            run_frame(vt[v].rows, vt[v].cols, vt[v].bd, vt[v].disp, "vec");
            be = (vt[v].bd == 0) ? 1 : vt[v].bd;
            for (int k = 0; k < be; k++) begin
                idx = vt[v].pos * be + k;
                e = {vt[v].exp_buf, AW'(vt[v].exp_addr), 3'(k), vt[v].exp_data[k], vt[v].exp_mask};
                if (idx < wlog.size()) check("vec_plane", 64'(wlog[idx]), 64'(e));
                else fail_now("vec_plane_missing");
            end
        end

        // Throughput and first-write latency at bitdepth 4.
        ctrl_n_rows = 4; ctrl_n_cols = 2; ctrl_bitdepth = 4; disp_buffer = 1'b0;
        idle(1);
        acc_cyc.delete();
        w0_cyc.delete();
        for (int i = 0; i < 8; i++) send(24'($urandom), i == 0);
        idle(8);
        if (acc_cyc.size() >= 3 && w0_cyc.size() >= 1) begin
            check("ready_period_a", 64'(acc_cyc[1] - acc_cyc[0]), 64'd5);
            check("ready_period_b", 64'(acc_cyc[2] - acc_cyc[1]), 64'd5);
            check("plane0_latency", 64'(w0_cyc[0] - acc_cyc[0]), 64'd1);
        end else fail_now("throughput_samples");

        // Pixels before any SOF are dropped; a SOF mid-frame restarts at address 0.
        ctrl_bitdepth = 8;
        idle(1);
        wlog.delete(); expq.delete();
        d0 = n_done; s0 = n_sof;
        for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0);
        idle(4);
        check("presof_nowr", 64'(wlog.size()), 64'd0);
        for (int i = 0; i < 10; i++) fpix[i] = 24'($urandom);
        model_pixel(fpix[0], 0, 0, 1'b1); send(fpix[0], 1'b1);
        model_pixel(fpix[1], 0, 1, 1'b1); send(fpix[1], 1'b0);
        model_pixel(fpix[2], 0, 0, 1'b1); send(fpix[2], 1'b1);
        for (int i = 1; i < 8; i++) begin
            model_pixel(fpix[i + 2], i / 2, i % 2, 1'b1);
            send(fpix[i + 2], 1'b0);
        end
        idle(12);
        compare_writes("sof_err");
        check("sof_err_cnt", 64'(n_sof - s0), 64'd1);
        check("sof_err_done", 64'(n_done - d0), 64'd1);
        if (wlog.size() > 16) check("sof_restart_addr", 64'(wlog[16].addr), 64'd0);
        else fail_now("sof_restart_addr");

        // Display swaps onto the write buffer twice in one frame.
        ctrl_bitdepth = 2; disp_buffer = 1'b0;
        idle(1);
        wlog.delete(); expq.delete();
        d0 = n_done; o0 = n_ovr;
        for (int i = 0; i < 8; i++) fpix[i] = 24'($urandom);
        for (int i = 0; i < 8; i++) begin
            model_pixel(fpix[i], i / 2, i % 2, 1'b1);
            send(fpix[i], i == 0);
            if (i == 2 || i == 5) begin
                disp_buffer = 1'b1;
                idle(3);
                disp_buffer = 1'b0;
            end
        end
        idle(8);
        compare_writes("ovr");
        check("ovr_cnt", 64'(n_ovr - o0), 64'd1);
        check("ovr_done", 64'(n_done - d0), 64'd1);

        // Reset asserted during plane 3.
        ctrl_bitdepth = 8;
        idle(1);
        send(24'($urandom), 1'b1);
        wait_plane3("rst_plane3_wait");
        #2;
        ctrl_rst_n = 1'b0;
        #1;
        check("rst_mid_outs", outs(), 64'd0);
        @(negedge clk);
        ctrl_rst_n = 1'b1;
        wlog.delete();
        d0 = n_done;
        send(24'($urandom), 1'b0);
        send(24'($urandom), 1'b0);
        idle(12);
        check("rst_nowr", 64'(wlog.size()), 64'd0);

        // Enable dropped during plane 3.
        send(24'($urandom), 1'b1);
        wait_plane3("en_plane3_wait");
        ctrl_en = 1'b0;
        @(negedge clk);
        check("en_drop_outs", outs(), 64'd0);
        wlog.delete();
        idle(3);
        check("en_low_ready", 64'(pix.ready), 64'd0);
        ctrl_en = 1'b1;
        send(24'($urandom), 1'b0);
        send(24'($urandom), 1'b0);
        idle(12);
        check("en_nowr", 64'(wlog.size()), 64'd0);
        check("abort_no_done", 64'(n_done - d0), 64'd0);

        // Random configurations and pixels against the reference model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 64; i++) fpix[i] = 24'($urandom);
            run_frame(2 * int'($urandom_range(1, 3)), int'($urandom_range(1, 4)),
                      int'($urandom_range(0, 8)), 1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
